// File: rtl/conduit_reg_pkg.sv
// Shared definitions for the conduit register bank: register offsets,
// FSM state encoding, register select codes and the default ID value.
package conduit_reg_pkg;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h0000_0A01;

  localparam logic [11:0] OFF_CTRL     = 12'h000;
  localparam logic [11:0] OFF_STATUS   = 12'h004;
  localparam logic [11:0] OFF_IRQ_STAT = 12'h008;
  localparam logic [11:0] OFF_IRQ_EN   = 12'h00C;
  localparam logic [11:0] OFF_SCRATCH  = 12'h010;
  localparam logic [11:0] OFF_ID       = 12'h014;

  // Wide enough for the largest supported RD_WAIT (7)
  localparam int WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_ACK  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_DONE = 2'd3
  } conduit_state_e;

  typedef enum logic [2:0] {
    SEL_CTRL     = 3'd0,
    SEL_STATUS   = 3'd1,
    SEL_IRQ_STAT = 3'd2,
    SEL_IRQ_EN   = 3'd3,
    SEL_SCRATCH  = 3'd4,
    SEL_ID       = 3'd5,
    SEL_NONE     = 3'd7
  } reg_sel_e;

endpackage

// File: rtl/conduit_irq_ctrl.sv
// Interrupt status/enable registers and the registered level interrupt.
// Status bits are sticky on events and cleared by write-one-to-clear;
// a simultaneous event wins over the clear.
module conduit_irq_ctrl
  import conduit_reg_pkg::*;
(
  input  logic       pclk,
  input  logic       presetn,
  input  logic [7:0] core_event,
  input  logic       stat_clr_en,
  input  logic       en_wr_en,
  input  logic [7:0] wr_byte,
  output logic [7:0] irq_stat,
  output logic [7:0] irq_en,
  output logic       irq
);

  logic [7:0] stat_r;
  logic [7:0] en_r;
  logic       irq_r;
  logic [7:0] clr_mask_s;

  // Bits to clear this cycle from an accepted W1C write
  always_comb begin
    clr_mask_s = 8'h00;
    if (stat_clr_en) begin
      clr_mask_s = wr_byte;
    end else begin
      clr_mask_s = 8'h00;
    end
  end

  // Sticky status: clear first, then OR in events so a same-cycle event wins
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      stat_r <= 8'h00;
    end else begin
      stat_r <= (stat_r & ~clr_mask_s) | core_event;
    end
  end

  // Enable mask register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      en_r <= 8'h00;
    end else if (en_wr_en) begin
      en_r <= wr_byte;
    end else begin
      en_r <= en_r;
    end
  end

  // Interrupt level follows the stored status/enable one cycle later
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(stat_r & en_r);
    end
  end

  assign irq_stat = stat_r;
  assign irq_en   = en_r;
  assign irq      = irq_r;

endmodule

// File: rtl/conduit_reg_bank.sv
// Conduit-attached register bank: CTRL/STATUS/IRQ/SCRATCH/ID registers,
// address decode and the request/acknowledge FSM. Writes commit when the
// request is accepted; reads return after RD_WAIT extra cycles.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module conduit_reg_bank
  import conduit_reg_pkg::*;
#(
  parameter int                 D_WIDTH  = `WORD_SIZE,
  parameter int                 A_WIDTH  = 12,
  parameter int                 RD_WAIT  = 1,
  parameter logic [D_WIDTH-1:0] ID_VALUE = D_WIDTH'(ID_VALUE_DEFAULT)
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 con_wr,
  input  logic                 con_rd,
  input  logic                 con_rd_ack,
  input  logic [A_WIDTH-1:0]   con_waddr,
  input  logic [A_WIDTH-1:0]   con_raddr,
  input  logic [D_WIDTH-1:0]   con_wdata,
  input  logic [D_WIDTH/8-1:0] con_wbyte_enable,
  input  logic [D_WIDTH/8-1:0] con_rbyte_enable,
  output logic                 con_wr_ack,
  output logic [D_WIDTH-1:0]   con_rdata,
  output logic                 con_read_valid,
  output logic                 con_slv_error,
  output logic [D_WIDTH-1:0]   core_ctrl,
  input  logic [D_WIDTH-1:0]   core_status,
  input  logic [7:0]           core_event,
  output logic                 irq
);

  localparam int BE_W = D_WIDTH / 8;

  conduit_state_e          state_r;
  logic [WAIT_CNT_W-1:0]   wait_cnt_r;
  logic [A_WIDTH-1:0]      raddr_r;
  logic [D_WIDTH-1:0]      ctrl_r;
  logic [D_WIDTH-1:0]      scratch_r;
  logic [D_WIDTH-1:0]      rdata_r;
  logic                    wr_ack_r;
  logic                    rd_valid_r;
  logic                    slv_err_r;

  reg_sel_e                wr_sel_s;
  reg_sel_e                rd_sel_s;
  logic [A_WIDTH-1:0]      rd_addr_s;
  logic [D_WIDTH-1:0]      rd_data_s;
  logic                    wr_fire_s;
  logic                    wr_err_s;
  logic                    wr_ok_s;
  logic                    rd_err_s;
  logic [7:0]              irq_stat_s;
  logic [7:0]              irq_en_s;

  // Read acknowledge and read byte enables carry no information for this block
  logic unused_inputs_s;
  assign unused_inputs_s = ^{con_rd_ack, con_rbyte_enable};

  function automatic reg_sel_e decode_addr(input logic [A_WIDTH-1:0] addr);
    reg_sel_e sel;
    if (addr[1:0] != 2'b00)                   sel = SEL_NONE;
    else if (addr == A_WIDTH'(OFF_CTRL))      sel = SEL_CTRL;
    else if (addr == A_WIDTH'(OFF_STATUS))    sel = SEL_STATUS;
    else if (addr == A_WIDTH'(OFF_IRQ_STAT))  sel = SEL_IRQ_STAT;
    else if (addr == A_WIDTH'(OFF_IRQ_EN))    sel = SEL_IRQ_EN;
    else if (addr == A_WIDTH'(OFF_SCRATCH))   sel = SEL_SCRATCH;
    else if (addr == A_WIDTH'(OFF_ID))        sel = SEL_ID;
    else                                      sel = SEL_NONE;
    return sel;
  endfunction

  function automatic logic [D_WIDTH-1:0] byte_merge(input logic [D_WIDTH-1:0] old_val,
                                                    input logic [D_WIDTH-1:0] new_val,
                                                    input logic [BE_W-1:0]    be);
    logic [D_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
      else       res[8*b +: 8] = old_val[8*b +: 8];
    end
    return res;
  endfunction

  assign wr_sel_s  = decode_addr(con_waddr);
  assign wr_fire_s = (state_r == ST_IDLE) && con_wr;
  assign wr_err_s  = (wr_sel_s == SEL_NONE) || (wr_sel_s == SEL_STATUS) || (wr_sel_s == SEL_ID);
  assign wr_ok_s   = wr_fire_s && !wr_err_s;

  // With no wait cycles the read completes on the accepting edge, so decode the live address
  always_comb begin
    rd_addr_s = raddr_r;
    if (state_r == ST_IDLE) begin
      rd_addr_s = con_raddr;
    end else begin
      rd_addr_s = raddr_r;
    end
  end

  assign rd_sel_s = decode_addr(rd_addr_s);
  assign rd_err_s = (rd_sel_s == SEL_NONE);

  // Read mux; unmapped addresses and unimplemented bits return zero
  always_comb begin
    rd_data_s = '0;
    case (rd_sel_s)
      SEL_CTRL:     rd_data_s = ctrl_r;
      SEL_STATUS:   rd_data_s = core_status;
      SEL_IRQ_STAT: rd_data_s = D_WIDTH'(irq_stat_s);
      SEL_IRQ_EN:   rd_data_s = D_WIDTH'(irq_en_s);
      SEL_SCRATCH:  rd_data_s = scratch_r;
      SEL_ID:       rd_data_s = ID_VALUE;
      default:      rd_data_s = '0;
    endcase
  end

  // CTRL and SCRATCH storage, byte-merged on accepted writes
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl_r    <= '0;
      scratch_r <= '0;
    end else begin
      if (wr_ok_s && (wr_sel_s == SEL_CTRL)) begin
        ctrl_r <= byte_merge(ctrl_r, con_wdata, con_wbyte_enable);
      end else begin
        ctrl_r <= ctrl_r;
      end
      if (wr_ok_s && (wr_sel_s == SEL_SCRATCH)) begin
        scratch_r <= byte_merge(scratch_r, con_wdata, con_wbyte_enable);
      end else begin
        scratch_r <= scratch_r;
      end
    end
  end

  // Request FSM with registered ack/valid/error pulses and read data
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
      raddr_r    <= '0;
      rdata_r    <= '0;
      wr_ack_r   <= 1'b0;
      rd_valid_r <= 1'b0;
      slv_err_r  <= 1'b0;
    end else begin
      wr_ack_r   <= 1'b0;
      rd_valid_r <= 1'b0;
      slv_err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (con_wr) begin
            state_r   <= ST_WR_ACK;
            wr_ack_r  <= 1'b1;
            slv_err_r <= wr_err_s;
          end else if (con_rd) begin
            raddr_r <= con_raddr;
            if (RD_WAIT > 0) begin
              state_r    <= ST_RD_WAIT;
              wait_cnt_r <= WAIT_CNT_W'(RD_WAIT - 1);
            end else begin
              state_r    <= ST_RD_DONE;
              rd_valid_r <= 1'b1;
              slv_err_r  <= rd_err_s;
              rdata_r    <= rd_data_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WR_ACK: begin
          state_r <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (wait_cnt_r == WAIT_CNT_W'(0)) begin
            state_r    <= ST_RD_DONE;
            rd_valid_r <= 1'b1;
            slv_err_r  <= rd_err_s;
            rdata_r    <= rd_data_s;
          end else begin
            wait_cnt_r <= wait_cnt_r - WAIT_CNT_W'(1);
          end
        end
        ST_RD_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  conduit_irq_ctrl u_irq_ctrl (
    .pclk        (pclk),
    .presetn     (presetn),
    .core_event  (core_event),
    .stat_clr_en (wr_ok_s && (wr_sel_s == SEL_IRQ_STAT) && con_wbyte_enable[0]),
    .en_wr_en    (wr_ok_s && (wr_sel_s == SEL_IRQ_EN) && con_wbyte_enable[0]),
    .wr_byte     (con_wdata[7:0]),
    .irq_stat    (irq_stat_s),
    .irq_en      (irq_en_s),
    .irq         (irq)
  );

  assign con_wr_ack     = wr_ack_r;
  assign con_read_valid = rd_valid_r;
  assign con_slv_error  = slv_err_r;
  assign con_rdata      = rdata_r;
  assign core_ctrl      = ctrl_r;

endmodule

// File: tb/tb_conduit_reg_bank.sv
// Bench for conduit_reg_bank: directed vector table, hand-written IRQ,
// collision and reset-abort sequences, then random traffic against a
// register-map reference model.
module tb_conduit_reg_bank;

  logic        pclk, presetn, presetn3;
  logic        con_wr, con_rd, con_rd3, con_rd_ack;
  logic [11:0] con_waddr, con_raddr, con_raddr3;
  logic [31:0] con_wdata, core_status;
  logic [3:0]  con_wbyte_enable, con_rbyte_enable;
  logic [7:0]  core_event;
  logic        con_wr_ack, con_read_valid, con_slv_error, irq;
  logic [31:0] con_rdata, core_ctrl;
  logic        con_wr_ack3, con_read_valid3, con_slv_error3, irq3;
  logic [31:0] con_rdata3, core_ctrl3;

  int errors = 0;
  int checks = 0;

  // Reference model of the register map
  logic [31:0] ctrl_m, scratch_m;
  logic [7:0]  stat_m, en_m;

  conduit_reg_bank #(.D_WIDTH(32), .A_WIDTH(12), .RD_WAIT(1)) dut (
    .pclk(pclk), .presetn(presetn), .con_wr(con_wr), .con_rd(con_rd),
    .con_rd_ack(con_rd_ack), .con_waddr(con_waddr), .con_raddr(con_raddr),
    .con_wdata(con_wdata), .con_wbyte_enable(con_wbyte_enable),
    .con_rbyte_enable(con_rbyte_enable), .con_wr_ack(con_wr_ack),
    .con_rdata(con_rdata), .con_read_valid(con_read_valid),
    .con_slv_error(con_slv_error), .core_ctrl(core_ctrl),
    .core_status(core_status), .core_event(core_event), .irq(irq));

  conduit_reg_bank #(.D_WIDTH(32), .A_WIDTH(12), .RD_WAIT(3)) dut3 (
    .pclk(pclk), .presetn(presetn3), .con_wr(1'b0), .con_rd(con_rd3),
    .con_rd_ack(con_rd_ack), .con_waddr(con_waddr), .con_raddr(con_raddr3),
    .con_wdata(con_wdata), .con_wbyte_enable(con_wbyte_enable),
    .con_rbyte_enable(con_rbyte_enable), .con_wr_ack(con_wr_ack3),
    .con_rdata(con_rdata3), .con_read_valid(con_read_valid3),
    .con_slv_error(con_slv_error3), .core_ctrl(core_ctrl3),
    .core_status(core_status), .core_event(8'h00), .irq(irq3));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic [7:0] ev, output logic err);
    logic [31:0] m;
    logic [7:0]  clr;
    m = 32'h0;
    clr = 8'h00;
    err = 1'b0;
    for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
    case (a)
      12'h000: ctrl_m    = (ctrl_m & ~m) | (d & m);
      12'h008: clr       = d[7:0] & m[7:0];
      12'h00C: en_m      = (en_m & ~m[7:0]) | (d[7:0] & m[7:0]);
      12'h010: scratch_m = (scratch_m & ~m) | (d & m);
      default: err = 1'b1;
    endcase
    stat_m = (stat_m & ~clr) | ev;
  endtask

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    err = 1'b0;
    case (a)
      12'h000: d = ctrl_m;
      12'h004: d = core_status;
      12'h008: d = {24'h0, stat_m};
      12'h00C: d = {24'h0, en_m};
      12'h010: d = scratch_m;
      12'h014: d = 32'h0000_0A01;
      default: begin d = 32'h0; err = 1'b1; end
    endcase
  endtask

  // Issue a write (with optional same-cycle event) and measure ack latency
  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic [7:0] ev, output logic e);
    int n;
    con_waddr = a; con_wdata = d; con_wbyte_enable = be; core_event = ev; con_wr = 1'b1;
    n = 0;
    do begin
      tick();
      con_wr = 1'b0; core_event = 8'h00;
      n++;
    end while (!con_wr_ack && n < 10);
    check("wr_latency", 32'(n), 32'd1);
    e = con_slv_error;
    tick();
    check("wr_pulse_end", {30'd0, con_wr_ack, con_slv_error}, 32'd0);
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    int n;
    con_raddr = a; con_rd = 1'b1;
    n = 0;
    do begin
      tick();
      con_rd = 1'b0;
      n++;
    end while (!con_read_valid && n < 10);
    check("rd_latency", 32'(n), 32'd2);
    d = con_rdata;
    e = con_slv_error;
    tick();
    check("rd_pulse_end", {30'd0, con_read_valid, con_slv_error}, 32'd0);
  endtask

  task automatic wr_chk(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [7:0] ev);
    logic e, me;
    do_write(a, d, be, ev, e);
    model_write(a, d, be, ev, me);
    check($sformatf("wr_err@%h", a), {31'd0, e}, {31'd0, me});
    check("irq_after_wr", {31'd0, irq}, {31'd0, |(stat_m & en_m)});
  endtask

  task automatic rd_chk(input logic [11:0] a);
    logic [31:0] d, md;
    logic e, me;
    do_read(a, d, e);
    model_read(a, md, me);
    check($sformatf("rd_data@%h", a), d, md);
    check($sformatf("rd_err@%h", a), {31'd0, e}, {31'd0, me});
    check("rdata_hold", con_rdata, md);
    check("irq_after_rd", {31'd0, irq}, {31'd0, |(stat_m & en_m)});
  endtask

  task automatic ev_pulse(input logic [7:0] ev);
    core_event = ev;
    tick();
    core_event = 8'h00;
    stat_m = stat_m | ev;
    tick();
    check("irq_after_ev", {31'd0, irq}, {31'd0, |(stat_m & en_m)});
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  logic [11:0] addrs[12] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                             12'h018, 12'h01C, 12'h002, 12'h007, 12'hFFC, 12'h011};

  logic [31:0] rd_d;
  logic        rd_e, wr_e, me;
  int          seen, n;

  initial begin
    vecs[0]  = '{1'b1, 12'h000, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 12'h000, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 12'h010, 32'h1111_1111, 4'hF, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 12'h010, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 12'h010, 32'h0,         4'h0, 1'b0, 32'h11BB_11DD};
    vecs[5]  = '{1'b1, 12'h014, 32'h1234_5678, 4'hF, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 12'h014, 32'h0,         4'h0, 1'b0, 32'h0000_0A01};
    vecs[7]  = '{1'b0, 12'h018, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 12'h002, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 12'h004, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 12'h004, 32'h0,         4'h0, 1'b0, 32'h5A5A_0F0F};
    vecs[11] = '{1'b1, 12'h001, 32'h0000_0000, 4'hF, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 12'h000, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
    vecs[13] = '{1'b1, 12'h00C, 32'hFFFF_FF04, 4'hF, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 12'h00C, 32'h0,         4'h0, 1'b0, 32'h0000_0004};
    vecs[15] = '{1'b0, 12'h008, 32'h0,         4'h0, 1'b0, 32'h0};

    presetn = 1'b0; presetn3 = 1'b0;
    con_wr = 1'b0; con_rd = 1'b0; con_rd3 = 1'b0; con_rd_ack = 1'b0;
    con_waddr = 12'h0; con_raddr = 12'h0; con_raddr3 = 12'h0;
    con_wdata = 32'h0; con_wbyte_enable = 4'h0; con_rbyte_enable = 4'hF;
    core_event = 8'h00; core_status = 32'h5A5A_0F0F;
    ctrl_m = 32'h0; scratch_m = 32'h0; stat_m = 8'h00; en_m = 8'h00;

    repeat (3) tick();
    check("reset_outputs", {28'd0, con_wr_ack, con_read_valid, con_slv_error, irq}, 32'd0);
    check("reset_rdata", con_rdata, 32'h0);
    check("reset_ctrl", core_ctrl, 32'h0);
    presetn = 1'b1;

    // Directed vector table; first request lands on the first edge after reset
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].be, 8'h00, wr_e);
        model_write(vecs[i].addr, vecs[i].data, vecs[i].be, 8'h00, me);
        check($sformatf("vec%0d_err", i), {31'd0, wr_e}, {31'd0, vecs[i].exp_err});
      end else begin
        do_read(vecs[i].addr, rd_d, rd_e);
        check($sformatf("vec%0d_data", i), rd_d, vecs[i].exp_rdata);
        check($sformatf("vec%0d_err", i), {31'd0, rd_e}, {31'd0, vecs[i].exp_err});
        check($sformatf("vec%0d_hold", i), con_rdata, vecs[i].exp_rdata);
      end
    end
    check("core_ctrl", core_ctrl, 32'hDEAD_BEEF);

    // IRQ: event sets status, irq follows one cycle later
    core_event = 8'h04;
    tick();
    core_event = 8'h00;
    stat_m = stat_m | 8'h04;
    check("irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    // W1C on bit 2 together with another event on bit 2: set wins
    wr_chk(12'h008, 32'h0000_0004, 4'h1, 8'h04);
    do_read(12'h008, rd_d, rd_e);
    check("stat_set_wins", rd_d, 32'h0000_0004);
    check("irq_stays", {31'd0, irq}, 32'd1);
    wr_chk(12'h008, 32'h0000_0004, 4'h1, 8'h00);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Simultaneous write and read: write served, read dropped; read during WR_ACK ignored
    con_waddr = 12'h010; con_wdata = 32'h1234_5678; con_wbyte_enable = 4'hF;
    con_raddr = 12'h000; con_wr = 1'b1; con_rd = 1'b1;
    tick();
    check("collide_ack", {31'd0, con_wr_ack}, 32'd1);
    con_wr = 1'b0;
    tick();
    con_rd = 1'b0;
    seen = 0;
    repeat (5) begin
      if (con_read_valid) seen++;
      tick();
    end
    check("collide_rd_dropped", 32'(seen), 32'd0);
    model_write(12'h010, 32'h1234_5678, 4'hF, 8'h00, me);
    rd_chk(12'h010);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      core_status = $urandom;
      con_rd_ack = 1'($urandom);
      case ($urandom_range(0, 3))
        0, 1: wr_chk(addrs[$urandom_range(0, 11)], $urandom, 4'($urandom), 8'($urandom));
        2:    rd_chk(addrs[$urandom_range(0, 11)]);
        default: ev_pulse(8'($urandom));
      endcase
    end
    con_rd_ack = 1'b0;

    // RD_WAIT=3 instance: latency, then reset asserted mid-read
    presetn3 = 1'b1;
    con_raddr3 = 12'h014; con_rd3 = 1'b1; n = 0;
    do begin tick(); con_rd3 = 1'b0; n++; end while (!con_read_valid3 && n < 12);
    check("rw3_latency", 32'(n), 32'd4);
    check("rw3_id", con_rdata3, 32'h0000_0A01);
    tick();
    con_raddr3 = 12'h000; con_rd3 = 1'b1;
    tick();
    con_rd3 = 1'b0;
    tick();
    #2 presetn3 = 1'b0;
    #1;
    check("rw3_async_rdata", con_rdata3, 32'h0);
    check("rw3_async_flags", {29'd0, con_wr_ack3, con_read_valid3, con_slv_error3}, 32'd0);
    tick();
    presetn3 = 1'b1;
    seen = 0;
    repeat (8) begin
      tick();
      if (con_read_valid3 || con_wr_ack3 || con_slv_error3) seen++;
    end
    check("rw3_abort", 32'(seen), 32'd0);
    check("rw3_outs_zero", con_rdata3 | core_ctrl3 | {31'd0, irq3}, 32'h0);
    con_raddr3 = 12'h014; con_rd3 = 1'b1; n = 0;
    do begin tick(); con_rd3 = 1'b0; n++; end while (!con_read_valid3 && n < 12);
    check("rw3_fresh_latency", 32'(n), 32'd4);
    check("rw3_fresh_id", con_rdata3, 32'h0000_0A01);
    check("rw3_fresh_err", {31'd0, con_slv_error3}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
